// File: rtl/nvme_sq_engine.sv
// rtl/nvme_sq_engine.sv - NVMe submission-queue issuer: SQE build, SQ ring write, tail doorbell, outstanding tracking
//
// Accepts read/write requests, builds a 64-byte SQE, and writes it as a single 512-bit
// AXI beat at SQ_BASE + 64*tail. It then rings the SQ tail doorbell over AXI-Lite and
// tracks the commands that have been submitted but not yet completed.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   cmd_valid/ready/write/slba/nlb/prp  request channel; cmd_cid is the CID given in the accept cycle
//   sq_aw*/sq_w*/sq_b*             AXI4 master, 512b data, single-beat INCR writes into the SQ ring
//   db_aw*/db_w*/db_b*             AXI4-Lite master, 32b tail doorbell write
//   cpl_valid                      one-cycle pulse for each completion consumed on the CQ side
//   outstanding                    commands rung to the controller and not yet completed
//   err                            sticky: non-OKAY bresp on either bus, or a completion while outstanding==0
//
// Build option NVME_SQ_DB_COALESCE_EN: when defined, up to DB_BATCH SQEs may share one
// doorbell write while requests keep arriving back to back. When undefined, every SQE
// gets its own doorbell write and DB_BATCH has no effect.
module nvme_sq_engine #(
    parameter int unsigned      DEPTH    = 16,
    parameter int unsigned      SQ_AW    = 32,
    parameter logic [SQ_AW-1:0] SQ_BASE  = 'h20000,
    parameter int unsigned      DB_AW    = 32,
    parameter logic [DB_AW-1:0] DB_ADDR  = 'h1008,
    parameter logic [31:0]      NSID     = 32'd1,
    parameter int unsigned      DB_BATCH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [63:0]              cmd_slba,
    input  logic [15:0]              cmd_nlb,
    input  logic [63:0]              cmd_prp,
    output logic [15:0]              cmd_cid,
    output logic                     sq_awvalid,
    input  logic                     sq_awready,
    output logic [SQ_AW-1:0]         sq_awaddr,
    output logic [7:0]               sq_awlen,
    output logic [2:0]               sq_awsize,
    output logic [1:0]               sq_awburst,
    output logic                     sq_wvalid,
    input  logic                     sq_wready,
    output logic [511:0]             sq_wdata,
    output logic [63:0]              sq_wstrb,
    output logic                     sq_wlast,
    input  logic                     sq_bvalid,
    output logic                     sq_bready,
    input  logic [1:0]               sq_bresp,
    output logic                     db_awvalid,
    input  logic                     db_awready,
    output logic [DB_AW-1:0]         db_awaddr,
    output logic                     db_wvalid,
    input  logic                     db_wready,
    output logic [31:0]              db_wdata,
    output logic [3:0]               db_wstrb,
    input  logic                     db_bvalid,
    output logic                     db_bready,
    input  logic [1:0]               db_bresp,
    input  logic                     cpl_valid,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err
);
    localparam int unsigned    TW    = $clog2(DEPTH);
    localparam int unsigned    CW    = TW + 1;
    localparam logic [CW-1:0]  CAP   = CW'(DEPTH - 1);
    localparam logic [CW-1:0]  BATCH = CW'(DB_BATCH);
`ifdef NVME_SQ_DB_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_SQW, S_SQB, S_DBW, S_DBB} state_t;

    state_t         state_q;
    logic           alive_q;
    logic [TW-1:0]  tail_q;
    logic [CW-1:0]  unrung_q;
    logic [CW-1:0]  out_q, out_d;
    logic           err_q;
    logic           write_q;
    logic [63:0]    slba_q;
    logic [15:0]    nlb_q;
    logic [63:0]    prp_q;
    logic           sq_awvalid_q, sq_wvalid_q, sq_bready_q;
    logic           db_awvalid_q, db_wvalid_q, db_bready_q;
    logic           cpl_ok, db_b_hs;

    // alive_q keeps cmd_ready low while reset is asserted even though the FSM already sits in IDLE.
    assign cmd_ready   = alive_q && (state_q == S_IDLE) && ((out_q + unrung_q) < CAP);
    assign cmd_cid     = 16'(tail_q);
    assign sq_awvalid  = sq_awvalid_q;
    assign sq_wvalid   = sq_wvalid_q;
    assign sq_bready   = sq_bready_q;
    assign sq_awaddr   = SQ_BASE + SQ_AW'({tail_q, 6'b0});
    assign sq_awlen    = 8'd0;
    assign sq_awsize   = 3'd6;
    assign sq_awburst  = 2'b01;
    assign sq_wstrb    = '1;
    assign sq_wlast    = 1'b1;
    assign db_awvalid  = db_awvalid_q;
    assign db_wvalid   = db_wvalid_q;
    assign db_bready   = db_bready_q;
    assign db_awaddr   = DB_ADDR;
    assign db_wdata    = 32'(tail_q);
    assign db_wstrb    = 4'hF;
    assign outstanding = out_q;
    assign err         = err_q;

    // SQE image; the CID equals the tail slot, which does not move until the SQ write response.
    always_comb begin
        sq_wdata          = '0;
        sq_wdata[31:0]    = {16'(tail_q), 2'b00, 6'b0, (write_q ? 8'h01 : 8'h02)};
        sq_wdata[63:32]   = NSID;
        sq_wdata[255:192] = prp_q;
        sq_wdata[383:320] = slba_q;
        sq_wdata[415:384] = {16'b0, nlb_q};
    end

    // Doorbell credit and completion debit may land in the same cycle; the debit is
    // judged against the count before the credit, so a completion at zero is an error.
    always_comb begin
        cpl_ok  = cpl_valid && (out_q != '0);
        db_b_hs = (state_q == S_DBB) && db_bvalid && db_bready_q;
        out_d   = out_q + (db_b_hs ? unrung_q : '0) - (cpl_ok ? CW'(1) : '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            alive_q      <= 1'b0;
            tail_q       <= '0;
            unrung_q     <= '0;
            out_q        <= '0;
            err_q        <= 1'b0;
            write_q      <= 1'b0;
            slba_q       <= '0;
            nlb_q        <= '0;
            prp_q        <= '0;
            sq_awvalid_q <= 1'b0;
            sq_wvalid_q  <= 1'b0;
            sq_bready_q  <= 1'b0;
            db_awvalid_q <= 1'b0;
            db_wvalid_q  <= 1'b0;
            db_bready_q  <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            out_q   <= out_d;
            if ((sq_bvalid && sq_bready_q && sq_bresp != 2'b00) ||
                (db_b_hs && db_bresp != 2'b00) ||
                (cpl_valid && out_q == '0)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        write_q      <= cmd_write;
                        slba_q       <= cmd_slba;
                        nlb_q        <= cmd_nlb;
                        prp_q        <= cmd_prp;
                        sq_awvalid_q <= 1'b1;
                        sq_wvalid_q  <= 1'b1;
                        state_q      <= S_SQW;
                    end
                end
                S_SQW: begin
                    if (sq_awready) sq_awvalid_q <= 1'b0;
                    if (sq_wready)  sq_wvalid_q  <= 1'b0;
                    if ((!sq_awvalid_q || sq_awready) && (!sq_wvalid_q || sq_wready)) begin
                        sq_bready_q <= 1'b1;
                        state_q     <= S_SQB;
                    end
                end
                S_SQB: begin
                    if (sq_bvalid) begin
                        sq_bready_q <= 1'b0;
                        tail_q      <= tail_q + TW'(1);
                        unrung_q    <= unrung_q + CW'(1);
                        // Skip the doorbell only while more work is queued behind this SQE
                        // and neither the batch limit nor the ring capacity is reached.
                        if (COALESCE && cmd_valid && ((unrung_q + CW'(1)) < BATCH) &&
                            ((out_q + unrung_q + CW'(1)) < CAP)) begin
                            state_q <= S_IDLE;
                        end else begin
                            db_awvalid_q <= 1'b1;
                            db_wvalid_q  <= 1'b1;
                            state_q      <= S_DBW;
                        end
                    end
                end
                S_DBW: begin
                    if (db_awready) db_awvalid_q <= 1'b0;
                    if (db_wready)  db_wvalid_q  <= 1'b0;
                    if ((!db_awvalid_q || db_awready) && (!db_wvalid_q || db_wready)) begin
                        db_bready_q <= 1'b1;
                        state_q     <= S_DBB;
                    end
                end
                S_DBB: begin
                    if (db_bvalid) begin
                        db_bready_q <= 1'b0;
                        unrung_q    <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nvme_sq_engine.sv
// tb/tb_nvme_sq_engine.sv - self-checking bench for nvme_sq_engine
module tb_nvme_sq_engine;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [63:0]  cmd_slba = '0, cmd_prp = '0;
    logic [15:0]  cmd_nlb = '0, cmd_cid;
    logic         sq_awvalid, sq_awready = 1'b0, sq_wvalid, sq_wready = 1'b0, sq_wlast;
    logic [31:0]  sq_awaddr;
    logic [7:0]   sq_awlen;
    logic [2:0]   sq_awsize;
    logic [1:0]   sq_awburst, sq_bresp = 2'b00, db_bresp = 2'b00;
    logic [511:0] sq_wdata;
    logic [63:0]  sq_wstrb;
    logic         sq_bvalid = 1'b0, sq_bready;
    logic         db_awvalid, db_awready = 1'b0, db_wvalid, db_wready = 1'b0;
    logic [31:0]  db_awaddr, db_wdata;
    logic [3:0]   db_wstrb;
    logic         db_bvalid = 1'b0, db_bready;
    logic         cpl_valid = 1'b0;
    logic [4:0]   outstanding;
    logic         err;

    int n_cmp  = 0;
    int n_fail = 0;

    nvme_sq_engine dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_slba(cmd_slba), .cmd_nlb(cmd_nlb), .cmd_prp(cmd_prp), .cmd_cid(cmd_cid),
        .sq_awvalid(sq_awvalid), .sq_awready(sq_awready), .sq_awaddr(sq_awaddr),
        .sq_awlen(sq_awlen), .sq_awsize(sq_awsize), .sq_awburst(sq_awburst),
        .sq_wvalid(sq_wvalid), .sq_wready(sq_wready), .sq_wdata(sq_wdata),
        .sq_wstrb(sq_wstrb), .sq_wlast(sq_wlast),
        .sq_bvalid(sq_bvalid), .sq_bready(sq_bready), .sq_bresp(sq_bresp),
        .db_awvalid(db_awvalid), .db_awready(db_awready), .db_awaddr(db_awaddr),
        .db_wvalid(db_wvalid), .db_wready(db_wready), .db_wdata(db_wdata), .db_wstrb(db_wstrb),
        .db_bvalid(db_bvalid), .db_bready(db_bready), .db_bresp(db_bresp),
        .cpl_valid(cpl_valid), .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [63:0] slba;
        logic [15:0] nlb;
        logic [63:0] prp;
        int          aw_dly;
        int          w_dly;
        logic [15:0] e_cid;
        logic [31:0] e_addr;
        logic [31:0] e_dw0;
        logic [31:0] e_db;
        logic [4:0]  e_out;
    } vec_t;

    typedef struct {
        logic [15:0]  cid;
        logic [31:0]  saddr;
        logic [511:0] sdata;
        logic [13:0]  sattr;
        logic [63:0]  sstrb;
        int           naw;
        int           nw;
        bit           dseen;
        logic [31:0]  daddr;
        logic [31:0]  ddata;
        logic [3:0]   dstrb;
        int           dnaw;
        int           dnw;
    } result_t;

    function automatic logic [511:0] sqe_model(input logic [15:0] cid, input logic wr,
                                               input logic [63:0] slba, input logic [15:0] nlb,
                                               input logic [63:0] prp);
        logic [31:0]  dw [16];
        logic [511:0] m;
        for (int i = 0; i < 16; i++) dw[i] = 32'h0;
        dw[0]  = {cid, 8'h00, (wr ? 8'h01 : 8'h02)};
        dw[1]  = 32'd1;
        dw[6]  = prp[31:0];
        dw[7]  = prp[63:32];
        dw[10] = slba[31:0];
        dw[11] = slba[63:32];
        dw[12] = {16'h0, nlb};
        m = '0;
        for (int i = 0; i < 16; i++) m[32*i +: 32] = dw[i];
        return m;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [63:0] slba, input logic [15:0] nlb,
                         input logic [63:0] prp, input bit keep, output logic [15:0] cid);
        bit got;
        got = 0;
        cid = '0;
        cmd_write = wr; cmd_slba = slba; cmd_nlb = nlb; cmd_prp = prp;
        cmd_valid = 1'b1;
        for (int c = 0; c < 60 && !got; c++) begin
            if (cmd_ready) begin
                got = 1;
                cid = cmd_cid;
            end
            tick;
        end
        cmd_valid = keep;
        chk("cmd_accept", got, 1);
    endtask

    // Write slave for either bus: independent aw/w ready delays, ready held high after the
    // handshake so a valid that fails to drop shows up as a second beat.
    task automatic slave(input bit db, input int aw_dly, input int w_dly, input logic [1:0] bresp,
                         input bit cpl_at_b, output logic [31:0] addr, output logic [511:0] data,
                         output logic [13:0] attr, output logic [63:0] strb,
                         output int naw, output int nw);
        bit ag, wg, bg, raw, rw, av, wv;
        ag = 0; wg = 0; bg = 0; naw = 0; nw = 0;
        addr = '0; data = '0; attr = '0; strb = '0;
        for (int c = 0; c < 40 && !(ag && wg); c++) begin
            raw = (c >= aw_dly);
            rw  = (c >= w_dly);
            if (db) begin
                db_awready = raw; db_wready = rw; av = db_awvalid; wv = db_wvalid;
            end else begin
                sq_awready = raw; sq_wready = rw; av = sq_awvalid; wv = sq_wvalid;
            end
            if (av && raw) begin
                naw++;
                if (!ag) begin
                    ag = 1;
                    addr = db ? db_awaddr : sq_awaddr;
                    attr[13:1] = {sq_awlen, sq_awsize, sq_awburst};
                end
            end
            if (wv && rw) begin
                nw++;
                if (!wg) begin
                    wg = 1;
                    data = db ? {480'b0, db_wdata} : sq_wdata;
                    strb = db ? {60'b0, db_wstrb} : sq_wstrb;
                    attr[0] = sq_wlast;
                end
            end
            tick;
        end
        sq_awready = 0; sq_wready = 0; db_awready = 0; db_wready = 0;
        chk(db ? "db_aw_w_done" : "sq_aw_w_done", {ag, wg}, 2'b11);
        chk(db ? "db_valid_drop" : "sq_valid_drop",
            db ? {db_awvalid, db_wvalid} : {sq_awvalid, sq_wvalid}, 2'b00);
        if (db) begin db_bvalid = 1; db_bresp = bresp; end
        else    begin sq_bvalid = 1; sq_bresp = bresp; end
        for (int c = 0; c < 20 && !bg; c++) begin
            if (db ? db_bready : sq_bready) begin
                bg = 1;
                if (cpl_at_b) cpl_valid = 1;
            end
            tick;
        end
        cpl_valid = 0;
        db_bvalid = 0; sq_bvalid = 0; db_bresp = 2'b00; sq_bresp = 2'b00;
        chk(db ? "db_b_done" : "sq_b_done", bg, 1);
    endtask

    task automatic run(input vec_t v, input logic [1:0] db_resp, input bit cpl_at_b,
                       input bit keep, output result_t r);
        logic [511:0] dd;
        logic [13:0]  da;
        logic [63:0]  ds;
        issue(v.wr, v.slba, v.nlb, v.prp, keep, r.cid);
        slave(0, v.aw_dly, v.w_dly, 2'b00, 0, r.saddr, r.sdata, r.sattr, r.sstrb, r.naw, r.nw);
        r.dseen = db_awvalid || db_wvalid;
        r.daddr = '0; r.ddata = '0; r.dstrb = '0; r.dnaw = 0; r.dnw = 0;
        if (r.dseen) begin
            slave(1, 0, 0, db_resp, cpl_at_b, r.daddr, dd, da, ds, r.dnaw, r.dnw);
            r.ddata = dd[31:0];
            r.dstrb = ds[3:0];
        end
    endtask

    task automatic pulse_cpl;
        cpl_valid = 1;
        tick;
        cpl_valid = 0;
    endtask

    task automatic do_reset;
        cmd_valid = 0;
        rstn = 0;
        tick;
        tick;
        rstn = 1;
        tick;
    endtask

    vec_t        vecs [4];
    vec_t        v;
    result_t     r;
    logic [31:0] db_seen [$];
    logic [31:0] db_exp [$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 64'h10, 16'd7, 64'h1000, 0, 0,
                    16'd0, 32'h20000, 32'h0000_0001, 32'd1, 5'd1};
        vecs[1] = '{1'b0, 64'h0000_0012_3456_789A, 16'hFFFF, 64'hDEAD_BEEF_0000_1000, 0, 5,
                    16'd1, 32'h20040, 32'h0001_0002, 32'd2, 5'd2};
        vecs[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, 64'h8000_0000_0000_0000, 5, 0,
                    16'd2, 32'h20080, 32'h0002_0001, 32'd3, 5'd3};
        vecs[3] = '{1'b0, 64'h55, 16'd3, 64'h2000, 3, 3,
                    16'd3, 32'h200C0, 32'h0003_0002, 32'd4, 5'd4};

        // Reset state, sampled while reset is still asserted.
        repeat (3) tick;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {sq_awvalid, sq_wvalid, db_awvalid, db_wvalid}, 4'b0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err, 0);
        rstn = 1;
        tick;
        chk("post_rst_ready", cmd_ready, 1);

        for (int i = 0; i < 4; i++) begin
            run(vecs[i], 2'b00, 0, 0, r);
            chk($sformatf("v%0d_cid", i), r.cid, vecs[i].e_cid);
            chk($sformatf("v%0d_sq_addr", i), r.saddr, vecs[i].e_addr);
            chk($sformatf("v%0d_dw0", i), r.sdata[31:0], vecs[i].e_dw0);
            chk($sformatf("v%0d_dw12", i), r.sdata[415:384], {16'h0, vecs[i].nlb});
            chk($sformatf("v%0d_sqe", i), r.sdata,
                sqe_model(vecs[i].e_cid, vecs[i].wr, vecs[i].slba, vecs[i].nlb, vecs[i].prp));
            chk($sformatf("v%0d_sq_attr", i), r.sattr, {8'h00, 3'd6, 2'b01, 1'b1});
            chk($sformatf("v%0d_sq_strb", i), r.sstrb, 64'hFFFF_FFFF_FFFF_FFFF);
            chk($sformatf("v%0d_sq_beats", i), {r.naw[7:0], r.nw[7:0]}, 16'h0101);
            chk($sformatf("v%0d_db_seen", i), r.dseen, 1);
            chk($sformatf("v%0d_db_addr", i), r.daddr, 32'h1008);
            chk($sformatf("v%0d_db_data", i), r.ddata, vecs[i].e_db);
            chk($sformatf("v%0d_db_strb", i), r.dstrb, 4'hF);
            chk($sformatf("v%0d_db_beats", i), {r.dnaw[7:0], r.dnw[7:0]}, 16'h0101);
            chk($sformatf("v%0d_outstanding", i), outstanding, vecs[i].e_out);
        end

        // Drain completions, then one completion too many.
        repeat (4) pulse_cpl;
        chk("drain_outstanding", outstanding, 0);
        chk("drain_err", err, 0);
        pulse_cpl;
        chk("cpl_at_zero_outstanding", outstanding, 0);
        chk("cpl_at_zero_err", err, 1);

        // Asynchronous reset in the middle of an SQ write.
        issue(1'b1, 64'h99, 16'd1, 64'h3000, 0, r.cid);
        chk("midrst_awvalid_before", sq_awvalid, 1);
        #2 rstn = 0;
        #1;
        chk("midrst_valids", {sq_awvalid, sq_wvalid}, 2'b00);
        chk("midrst_ready", cmd_ready, 0);
        chk("midrst_err", err, 0);
        tick;
        rstn = 1;
        tick;

        // Fill the ring: 15 commands with no completions.
        run(vecs[0], 2'b00, 0, 0, r);
        chk("fill0_cid", r.cid, 16'd0);
        chk("fill0_addr", r.saddr, 32'h20000);
        for (int i = 1; i < 15; i++) begin
            v = '{1'b1, 64'(i), 16'(i), 64'h4000, 0, 0, 16'd0, 32'd0, 32'd0, 32'd0, 5'd0};
            run(v, 2'b00, 0, 0, r);
        end
        chk("fill14_db_data", r.ddata, 32'd15);
        chk("full_outstanding", outstanding, 15);
        chk("full_ready_low", cmd_ready, 0);
        pulse_cpl;
        chk("after_cpl_outstanding", outstanding, 14);
        chk("after_cpl_ready", cmd_ready, 1);

        // 16th command lands in the last slot; its doorbell response coincides with a completion.
        v = '{1'b0, 64'hABC, 16'd2, 64'h5000, 0, 0, 16'd0, 32'd0, 32'd0, 32'd0, 5'd0};
        run(v, 2'b00, 1, 0, r);
        chk("wrap_cid", r.cid, 16'd15);
        chk("wrap_sq_addr", r.saddr, 32'h203C0);
        chk("wrap_db_data", r.ddata, 32'd0);
        chk("coincident_outstanding", outstanding, 14);
        chk("coincident_err", err, 0);

        // Doorbell SLVERR sets err; the next command is issued normally.
        run(v, 2'b10, 0, 0, r);
        chk("slverr_err", err, 1);
        chk("slverr_outstanding", outstanding, 15);
        chk("slverr_sq_addr", r.saddr, 32'h20000);
        pulse_cpl;
        run(vecs[1], 2'b00, 0, 0, r);
        chk("post_err_cid", r.cid, 16'd1);
        chk("post_err_sqe", r.sdata, sqe_model(16'd1, vecs[1].wr, vecs[1].slba, vecs[1].nlb, vecs[1].prp));
        chk("post_err_db_data", r.ddata, 32'd2);
        chk("post_err_outstanding", outstanding, 15);
        chk("post_err_err_sticky", err, 1);

        // Six back-to-back commands: doorbell pattern depends on coalescing.
        do_reset;
        chk("reset2_err", err, 0);
        for (int i = 0; i < 6; i++) begin
            v = '{1'b1, 64'(100 + i), 16'd0, 64'h6000, 0, 0, 16'd0, 32'd0, 32'd0, 32'd0, 5'd0};
            run(v, 2'b00, 0, (i < 5), r);
            if (r.dseen) db_seen.push_back(r.ddata);
        end
`ifdef NVME_SQ_DB_COALESCE_EN
        db_exp = '{32'd4, 32'd6};
`else
        db_exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
`endif
        chk("batch_db_count", db_seen.size(), db_exp.size());
        for (int i = 0; i < db_exp.size() && i < db_seen.size(); i++)
            chk($sformatf("batch_db%0d_data", i), db_seen[i], db_exp[i]);
        chk("batch_outstanding", outstanding, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
